// File: rtl/if_id_hazard_pkg.sv
// Shared definitions for the IF/ID register and hazard unit.
// Latency: n/a (constants, types and field helpers only).
// Backpressure: n/a.
package if_id_hazard_pkg;

    // Register-specifier field positions in a MIPS instruction word.
    localparam int RS_MSB = 25;
    localparam int RT_MSB = 20;
    localparam int REG_W  = 5;

    // sll $0,$0,0 -- the canonical MIPS nop.
    localparam logic [31:0] NOP_INS = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    function automatic logic [REG_W-1:0] field_rs(input logic [31:0] ins);
        return ins[RS_MSB -: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] field_rt(input logic [31:0] ins);
        return ins[RT_MSB -: REG_W];
    endfunction

endpackage

// File: rtl/if_id_hazard_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Latency: count reflects an inc one falling clock edge later.
// Backpressure: none; increments are dropped once saturated.
//
// Ports: clk (updates on falling edge), rst (async active-low clear),
//        inc (count this cycle), count (current value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use stall and branch/jump squash control.
// Latency: one falling edge IF->ID; STALL_CYCLES bubbles per load-use hazard.
// Backpressure: holds IF/ID and drops PCWrite while stalling; redirects win.
//
// Ports: IF_PC/IF_ins in from fetch; EX_* hazard and redirect info from EX;
//        ID_PC/ID_ins/ID_valid to decode; PCWrite to the PC register;
//        EXflush to the ID/EX register; stall_count/flush_count statistics.
module if_id_hazard
    import if_id_hazard_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IF_PC,
    input  logic [31:0]      IF_ins,
    input  logic             EX_MemtoReg,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_rt,
    input  logic             EX_BranchTaken,
    input  logic             EX_Jump,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_ins,
    output logic             ID_valid,
    output logic             PCWrite,
    output logic             EXflush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Bubbles still owed after the one issued on entry from RUN.
    localparam logic [2:0] STALL_RELOAD = 3'(STALL_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] bub_cnt, bub_cnt_nxt;
    logic       hz, rd;
    logic       ifid_load, squash, stall_inc, flush_inc;

    // Load in EX targets a source of the instruction in ID; $0 never conflicts.
    assign hz = ID_valid && EX_MemtoReg && EX_RegWrite && (EX_rt != '0) &&
                ((EX_rt == field_rs(ID_ins)) || (EX_rt == field_rt(ID_ins)));

    assign rd = EX_BranchTaken || EX_Jump;

    always_comb begin
        state_nxt   = state;
        bub_cnt_nxt = bub_cnt;
        PCWrite     = 1'b1;
        EXflush     = 1'b0;
        ifid_load   = 1'b0;
        squash      = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        // While reset is held the control outputs sit at their idle values,
        // whatever EX is presenting.
        if (rst) begin
            if (rd) begin
                // A redirect kills the wrong-path instruction in ID and also
                // abandons any stall, since the stalled instruction is dead.
                EXflush     = 1'b1;
                squash      = 1'b1;
                flush_inc   = 1'b1;
                state_nxt   = RUN;
                bub_cnt_nxt = '0;
            end else if (state == STALL) begin
                // hz is deliberately not re-checked: the bubble count was
                // fixed when the hazard was detected.
                PCWrite     = 1'b0;
                EXflush     = 1'b1;
                stall_inc   = 1'b1;
                bub_cnt_nxt = bub_cnt - 3'd1;
                if (bub_cnt == 3'd1) begin
                    state_nxt = RUN;
                end
            end else if (hz) begin
                PCWrite   = 1'b0;
                EXflush   = 1'b1;
                stall_inc = 1'b1;
                if (STALL_CYCLES > 1) begin
                    state_nxt   = STALL;
                    bub_cnt_nxt = STALL_RELOAD;
                end
            end else begin
                ifid_load = 1'b1;
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            bub_cnt  <= '0;
            ID_PC    <= '0;
            ID_ins   <= NOP_INS;
            ID_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_cnt_nxt;
            if (squash) begin
                ID_PC    <= IF_PC;
                ID_ins   <= NOP_INS;
                ID_valid <= 1'b0;
            end else if (ifid_load) begin
                ID_PC    <= IF_PC;
                ID_ins   <= IF_ins;
                ID_valid <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_if_id_hazard.sv
// Bench for if_id_hazard: one instance with single-bubble stalls, one with
// three-bubble stalls and 2-bit counters so saturation is reachable.
// Expected per-cycle results are queued with the stimulus and popped on output.
module tb_if_id_hazard;

    localparam int SC_A = 1;
    localparam int SC_B = 3;
    localparam int CW_A = 16;
    localparam int CW_B = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        mtr;
        logic        rw;
        logic [4:0]  rt;
        logic        br;
        logic        jmp;
    } vec_t;

    typedef struct packed {
        logic        pcw;
        logic        exfl;
        logic [31:0] id_pc;
        logic [31:0] id_ins;
        logic        id_valid;
        logic [15:0] sc;
        logic [15:0] fc;
    } obs_t;

    logic        clk;
    logic        rst;
    logic [31:0] IF_PC, IF_ins;
    logic        EX_MemtoReg, EX_RegWrite, EX_BranchTaken, EX_Jump;
    logic [4:0]  EX_rt;

    logic [31:0]     a_id_pc, a_id_ins, b_id_pc, b_id_ins;
    logic            a_id_valid, a_pcw, a_exfl, b_id_valid, b_pcw, b_exfl;
    logic [CW_A-1:0] a_sc, a_fc;
    logic [CW_B-1:0] b_sc, b_fc;

    int vectors     = 0;
    int miscompares = 0;

    vec_t stim_q[$];
    obs_t exp_q[$];

    if_id_hazard #(.STALL_CYCLES(SC_A), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .IF_PC(IF_PC), .IF_ins(IF_ins),
        .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite), .EX_rt(EX_rt),
        .EX_BranchTaken(EX_BranchTaken), .EX_Jump(EX_Jump),
        .ID_PC(a_id_pc), .ID_ins(a_id_ins), .ID_valid(a_id_valid),
        .PCWrite(a_pcw), .EXflush(a_exfl),
        .stall_count(a_sc), .flush_count(a_fc)
    );

    if_id_hazard #(.STALL_CYCLES(SC_B), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .IF_PC(IF_PC), .IF_ins(IF_ins),
        .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite), .EX_rt(EX_rt),
        .EX_BranchTaken(EX_BranchTaken), .EX_Jump(EX_Jump),
        .ID_PC(b_id_pc), .ID_ins(b_id_ins), .ID_valid(b_id_valid),
        .PCWrite(b_pcw), .EXflush(b_exfl),
        .stall_count(b_sc), .flush_count(b_fc)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        assert (SC_A >= 1 && SC_A <= 7 && SC_B >= 1 && SC_B <= 7)
            else $fatal(1, "STALL_CYCLES outside 1..7");
    end

    function automatic vec_t mk_v(input logic [31:0] pc, input logic [31:0] ins,
                                  input logic mtr, input logic rw, input logic [4:0] rt,
                                  input logic br, input logic jmp);
        vec_t v;
        v.pc = pc; v.ins = ins; v.mtr = mtr; v.rw = rw; v.rt = rt; v.br = br; v.jmp = jmp;
        return v;
    endfunction

    function automatic obs_t mk_e(input logic pcw, input logic exfl, input logic [31:0] pc,
                                  input logic [31:0] ins, input logic vld,
                                  input logic [15:0] sc, input logic [15:0] fc);
        obs_t e;
        e.pcw = pcw; e.exfl = exfl; e.id_pc = pc; e.id_ins = ins;
        e.id_valid = vld; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    function automatic obs_t sample(input bit use_b);
        obs_t o;
        if (use_b) o = mk_e(b_pcw, b_exfl, b_id_pc, b_id_ins, b_id_valid, 16'(b_sc), 16'(b_fc));
        else       o = mk_e(a_pcw, a_exfl, a_id_pc, a_id_ins, a_id_valid, 16'(a_sc), 16'(a_fc));
        return o;
    endfunction

    // Called just after a falling edge: drives one cycle of inputs, captures the
    // combinational controls before the next falling edge and the registered
    // state just after it.
    task automatic apply_cycle(input vec_t v, input bit use_b, output obs_t o);
        obs_t pre;
        IF_PC = v.pc; IF_ins = v.ins; EX_MemtoReg = v.mtr; EX_RegWrite = v.rw;
        EX_rt = v.rt; EX_BranchTaken = v.br; EX_Jump = v.jmp;
        #3;
        pre = sample(use_b);
        @(negedge clk);
        #1;
        o = sample(use_b);
        o.pcw  = pre.pcw;
        o.exfl = pre.exfl;
    endtask

    task automatic clear_inputs();
        IF_PC = '0; IF_ins = '0; EX_MemtoReg = 0; EX_RegWrite = 0;
        EX_rt = '0; EX_BranchTaken = 0; EX_Jump = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        clear_inputs();
        EX_Jump = 1'b1;  // controls must still read idle under reset
        rst = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            exp_q.push_back(mk_e(1, 0, 0, 0, 0, 0, 0));
            o = sample(d != 0);
            e = exp_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset dut%0d got %h expected %h", d, o, e);
            end
        end
        @(negedge clk);
        #1;
        EX_Jump = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_pass_through();
        obs_t o, e;
        stim_q.push_back(mk_v(32'h4, 32'h8C010004, 0, 0, 0, 0, 0));
        exp_q.push_back(mk_e(1, 0, 32'h4, 32'h8C010004, 1, 0, 0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_cycle(stim_q.pop_front(), 0, o);
            e = exp_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL pass_through[%0d] got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_load_use_single();
        obs_t o, e;
        stim_q.push_back(mk_v(32'h8, 32'h00221820, 0, 0, 0, 0, 0));
        exp_q.push_back(mk_e(1, 0, 32'h8, 32'h00221820, 1, 0, 0));
        stim_q.push_back(mk_v(32'hC, 32'hAC030008, 1, 1, 5'd1, 0, 0));
        exp_q.push_back(mk_e(0, 1, 32'h8, 32'h00221820, 1, 1, 0));
        stim_q.push_back(mk_v(32'hC, 32'hAC030008, 0, 0, 0, 0, 0));
        exp_q.push_back(mk_e(1, 0, 32'hC, 32'hAC030008, 1, 1, 0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_cycle(stim_q.pop_front(), 0, o);
            e = exp_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL load_use_single[%0d] got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_rt_zero();
        obs_t o, e;
        stim_q.push_back(mk_v(32'h10, 32'h8C040000, 1, 1, 5'd0, 0, 0));
        exp_q.push_back(mk_e(1, 0, 32'h10, 32'h8C040000, 1, 1, 0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_cycle(stim_q.pop_front(), 0, o);
            e = exp_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rt_zero[%0d] got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_multi_stall_saturate();
        obs_t o, e;
        do_reset();
        stim_q.push_back(mk_v(32'h8, 32'h00221820, 0, 0, 0, 0, 0));
        exp_q.push_back(mk_e(1, 0, 32'h8, 32'h00221820, 1, 0, 0));
        stim_q.push_back(mk_v(32'hC, 32'hAC030008, 1, 1, 5'd2, 0, 0));
        exp_q.push_back(mk_e(0, 1, 32'h8, 32'h00221820, 1, 1, 0));
        for (int k = 2; k <= 3; k++) begin
            stim_q.push_back(mk_v(32'hC, 32'hAC030008, 0, 0, 0, 0, 0));
            exp_q.push_back(mk_e(0, 1, 32'h8, 32'h00221820, 1, 16'(k), 0));
        end
        stim_q.push_back(mk_v(32'hC, 32'hAC030008, 0, 0, 0, 0, 0));
        exp_q.push_back(mk_e(1, 0, 32'hC, 32'hAC030008, 1, 3, 0));
        // Second hazard: the 2-bit stall counter is already all-ones.
        stim_q.push_back(mk_v(32'h10, 32'h8C040000, 1, 1, 5'd3, 0, 0));
        exp_q.push_back(mk_e(0, 1, 32'hC, 32'hAC030008, 1, 3, 0));
        for (int k = 0; k < 2; k++) begin
            stim_q.push_back(mk_v(32'h10, 32'h8C040000, 0, 0, 0, 0, 0));
            exp_q.push_back(mk_e(0, 1, 32'hC, 32'hAC030008, 1, 3, 0));
        end
        stim_q.push_back(mk_v(32'h10, 32'h8C040000, 0, 0, 0, 0, 0));
        exp_q.push_back(mk_e(1, 0, 32'h10, 32'h8C040000, 1, 3, 0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_cycle(stim_q.pop_front(), 1, o);
            e = exp_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL multi_stall[%0d] got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_branch_over_hazard();
        obs_t o, e;
        do_reset();
        stim_q.push_back(mk_v(32'h8, 32'h00221820, 0, 0, 0, 0, 0));
        exp_q.push_back(mk_e(1, 0, 32'h8, 32'h00221820, 1, 0, 0));
        stim_q.push_back(mk_v(32'hC, 32'hAC030008, 1, 1, 5'd1, 1, 0));
        exp_q.push_back(mk_e(1, 1, 32'hC, 32'h0, 0, 0, 1));
        stim_q.push_back(mk_v(32'h10, 32'h8C040000, 0, 0, 0, 0, 0));
        exp_q.push_back(mk_e(1, 0, 32'h10, 32'h8C040000, 1, 0, 1));
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_cycle(stim_q.pop_front(), 0, o);
            e = exp_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL branch_over_hazard[%0d] got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_jump_in_stall_then_reset();
        obs_t o, e;
        do_reset();
        stim_q.push_back(mk_v(32'h8, 32'h00221820, 0, 0, 0, 0, 0));
        exp_q.push_back(mk_e(1, 0, 32'h8, 32'h00221820, 1, 0, 0));
        stim_q.push_back(mk_v(32'hC, 32'hAC030008, 1, 1, 5'd1, 0, 0));
        exp_q.push_back(mk_e(0, 1, 32'h8, 32'h00221820, 1, 1, 0));
        stim_q.push_back(mk_v(32'h40, 32'h8C050000, 0, 0, 0, 0, 1));
        exp_q.push_back(mk_e(1, 1, 32'h40, 32'h0, 0, 1, 1));
        stim_q.push_back(mk_v(32'h44, 32'h24060001, 0, 0, 0, 0, 0));
        exp_q.push_back(mk_e(1, 0, 32'h44, 32'h24060001, 1, 1, 1));
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_cycle(stim_q.pop_front(), 1, o);
            e = exp_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL jump_in_stall[%0d] got %h expected %h", i, o, e);
            end
        end
        // Mid-cycle asynchronous reset with a redirect being presented.
        EX_BranchTaken = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_q.push_back(mk_e(1, 0, 0, 0, 0, 0, 0));
            o = sample(d != 0);
            e = exp_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL async_reset dut%0d got %h expected %h", d, o, e);
            end
        end
        EX_BranchTaken = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use_single();
        test_rt_zero();
        test_multi_stall_saturate();
        test_branch_over_hazard();
        test_jump_in_stall_then_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
